// File: rtl/solver_job_feeder.sv
// Feeds job descriptors (header + real/imag limbs of c) into the solver, starts it, returns tagged result.
// Optional feature macro SOLVER_CYCLE_COUNT_EN: report the solve cycle count on res_cycles.
module solver_job_feeder #(
  parameter int LIMB_INDEX_BITS = 6,
  parameter int LIMB_BITS       = 32,
  parameter int TAG_BITS        = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LIMB_BITS-1:0]       in_data,
  output logic                       wr_real_en,
  output logic                       wr_imag_en,
  output logic [LIMB_INDEX_BITS-1:0] wr_ind,
  output logic [LIMB_BITS-1:0]       c_wr_data,
  output logic                       wr_num_limbs_en,
  output logic [LIMB_INDEX_BITS-1:0] num_limbs_data,
  output logic                       wr_iter_lim_en,
  output logic [15:0]                iter_lim_data,
  output logic                       start,
  input  logic                       solver_done,
  input  logic [15:0]                solver_count,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [15:0]                res_count,
  output logic [TAG_BITS-1:0]        res_tag,
  output logic                       res_err,
  output logic [31:0]                res_cycles
);

  typedef enum logic [2:0] {HDR, RE, IM, ISSUE, WAIT, RESULT} state_t;

  localparam logic [LIMB_INDEX_BITS-1:0] ONE = LIMB_INDEX_BITS'(1);

  state_t                     state;
  logic [LIMB_INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]        tag;
  logic                       accept;
  logic                       slot_free;
  logic                       last_limb;
  logic [31:0]                cycles_snapshot;

  assign accept    = in_valid & in_ready;
  // The result slot can take a new entry if empty or being drained this very cycle.
  assign slot_free = !res_valid || res_ready;
  // num_limbs_data doubles as the latched N for the running descriptor.
  assign last_limb = (idx == num_limbs_data - ONE);

`ifdef SOLVER_CYCLE_COUNT_EN
  logic [31:0] cycle_count;

  // Zero while start is high, then counts every WAIT cycle; saturates.
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_count <= '0;
    end else if (state == ISSUE && slot_free) begin
      cycle_count <= '0;
    end else if (state == WAIT && cycle_count != '1) begin
      cycle_count <= cycle_count + 32'd1;
    end
  end

  assign cycles_snapshot = cycle_count;
`else
  assign cycles_snapshot = '0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= HDR;
      idx             <= '0;
      tag             <= '0;
      in_ready        <= 1'b0;
      wr_real_en      <= 1'b0;
      wr_imag_en      <= 1'b0;
      wr_ind          <= '0;
      c_wr_data       <= '0;
      wr_num_limbs_en <= 1'b0;
      num_limbs_data  <= '0;
      wr_iter_lim_en  <= 1'b0;
      iter_lim_data   <= '0;
      start           <= 1'b0;
      res_valid       <= 1'b0;
      res_count       <= '0;
      res_tag         <= '0;
      res_err         <= 1'b0;
      res_cycles      <= '0;
    end else begin
      wr_real_en      <= 1'b0;
      wr_imag_en      <= 1'b0;
      wr_num_limbs_en <= 1'b0;
      wr_iter_lim_en  <= 1'b0;
      start           <= 1'b0;
      if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end

      case (state)
        HDR: begin
          in_ready <= 1'b1;
          if (accept) begin
            iter_lim_data   <= in_data[15:0];
            num_limbs_data  <= in_data[16 +: LIMB_INDEX_BITS];
            tag             <= in_data[24 +: TAG_BITS];
            wr_num_limbs_en <= 1'b1;
            wr_iter_lim_en  <= 1'b1;
            idx             <= '0;
            if (in_data[16 +: LIMB_INDEX_BITS] == '0) begin
              in_ready <= 1'b0;
              state    <= RESULT;
            end else begin
              state <= RE;
            end
          end
        end

        RE: begin
          in_ready <= 1'b1;
          if (accept) begin
            wr_real_en <= 1'b1;
            wr_ind     <= idx;
            c_wr_data  <= in_data;
            if (last_limb) begin
              idx   <= '0;
              state <= IM;
            end else begin
              idx <= idx + ONE;
            end
          end
        end

        IM: begin
          in_ready <= 1'b1;
          if (accept) begin
            wr_imag_en <= 1'b1;
            wr_ind     <= idx;
            c_wr_data  <= in_data;
            if (last_limb) begin
              idx      <= '0;
              in_ready <= 1'b0;
              state    <= ISSUE;
            end else begin
              idx <= idx + ONE;
            end
          end
        end

        ISSUE: begin
          in_ready <= 1'b0;
          if (slot_free) begin
            start <= 1'b1;
            state <= WAIT;
          end
        end

        // solver_done may still show the previous result while start is high, so skip that cycle.
        WAIT: begin
          in_ready <= 1'b0;
          if (!start && solver_done) begin
            res_valid  <= 1'b1;
            res_count  <= solver_count;
            res_tag    <= tag;
            res_err    <= 1'b0;
            res_cycles <= cycles_snapshot;
            in_ready   <= 1'b1;
            state      <= HDR;
          end
        end

        RESULT: begin
          in_ready <= 1'b0;
          if (slot_free) begin
            res_valid  <= 1'b1;
            res_count  <= '0;
            res_tag    <= tag;
            res_err    <= 1'b1;
            res_cycles <= '0;
            in_ready   <= 1'b1;
            state      <= HDR;
          end
        end

        default: begin
          in_ready <= 1'b0;
          state    <= HDR;
        end
      endcase
    end
  end

endmodule
